ball_collision_det: RTL and testbench

Paddle/ball collision detector for the pong datapath, in the `pclk` domain. Consumes the ball centre position from the horizontal and vertical ball movers and both paddle positions. Produces the `collision_det` level that the horizontal mover samples on its once-per-800 000-cycle step. Holds the flag until the mover has demonstrably reacted, then re-arms only after the ball leaves the paddle zone. Also detects wall misses for the score logic.

---
 rtl/ball_collision_det.sv | 146 ++++++++++++++
 tb/tb_ball_collision_det.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_collision_det.sv
// Paddle/ball collision detector: registered zone/wall flags feed a HIT/RELEASE FSM.
// Wall-miss pulses and score counters exist only when COLLISION_SCORE_EN is defined.
module ball_collision_det #(
    parameter int unsigned BALL_R     = 10,
    parameter int unsigned PADDLE_L_X = 30,
    parameter int unsigned PADDLE_R_X = 983,
    parameter int unsigned PADDLE_W   = 10,
    parameter int unsigned PADDLE_H   = 100,
    parameter int unsigned HOLD_MAX   = 1_700_000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    input  logic [11:0] pad_l_y,
    input  logic [11:0] pad_r_y,
    output logic        collision_det,
    output logic        hit_side,
    output logic        miss_l,
    output logic        miss_r,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r
);
    localparam int unsigned CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [1:0] {IDLE, HIT, RELEASE} state_t;

    // 13-bit operands so that position + offset never wraps
    logic [12:0] bx, by, pl, pr;
    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign pl = {1'b0, pad_l_y};
    assign pr = {1'b0, pad_r_y};

    logic vert_l, vert_r, zone_l, zone_r;
    assign vert_l = (by + 13'(BALL_R) >= pl) && (by < pl + 13'(PADDLE_H + BALL_R));
    assign vert_r = (by + 13'(BALL_R) >= pr) && (by < pr + 13'(PADDLE_H + BALL_R));
    assign zone_l = vert_l && (bx <= 13'(PADDLE_L_X + PADDLE_W + BALL_R))
                           && (bx >  13'(PADDLE_L_X + BALL_R));
    assign zone_r = vert_r && (bx + 13'(BALL_R) >= 13'(PADDLE_R_X))
                           && (bx + 13'(BALL_R) <  13'(PADDLE_R_X + PADDLE_W));

    logic        zone_l_q, zone_r_q;
    logic [11:0] x_q;
    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0] hit_x_q, hit_x_d;
    logic        side_q, side_d;
    logic        col_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            zone_l_q <= 1'b0;
            zone_r_q <= 1'b0;
            x_q      <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hit_x_q  <= '0;
            side_q   <= 1'b0;
            col_q    <= 1'b0;
        end else begin
            zone_l_q <= zone_l;
            zone_r_q <= zone_r;
            x_q      <= ball_x;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hit_x_q  <= hit_x_d;
            side_q   <= side_d;
            col_q    <= (state_d == HIT);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_x_d = hit_x_q;
        side_d  = side_q;
        case (state_q)
            IDLE: begin
                if (zone_l_q || zone_r_q) begin
                    state_d = HIT;
                    side_d  = !zone_l_q;
                    hit_x_d = x_q;
                    cnt_d   = '0;
                end
            end
            HIT: begin
                // a moved ball proves the mover has sampled the flag
                if ((x_q != hit_x_q) || (cnt_q == CNT_W'(HOLD_MAX - 1)))
                    state_d = RELEASE;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            RELEASE: begin
                if (!zone_l_q && !zone_r_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign collision_det = col_q;
    assign hit_side      = side_q;

`ifdef COLLISION_SCORE_EN
    logic       wall_l_q, wall_r_q, wall_l_p_q, wall_r_p_q;
    logic       miss_l_q, miss_r_q;
    logic [3:0] score_l_q, score_r_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wall_l_q   <= 1'b0;
            wall_r_q   <= 1'b0;
            wall_l_p_q <= 1'b0;
            wall_r_p_q <= 1'b0;
            miss_l_q   <= 1'b0;
            miss_r_q   <= 1'b0;
            score_l_q  <= '0;
            score_r_q  <= '0;
        end else begin
            wall_l_q   <= (bx <= 13'(BALL_R));
            wall_r_q   <= (bx + 13'(BALL_R) >= 13'd1023);
            wall_l_p_q <= wall_l_q;
            wall_r_p_q <= wall_r_q;
            miss_l_q   <= wall_l_q && !wall_l_p_q;
            miss_r_q   <= wall_r_q && !wall_r_p_q;
            // a left-wall miss is a point for the right player and vice versa
            if (miss_l_q && (score_r_q != 4'd15))
                score_r_q <= score_r_q + 4'd1;
            if (miss_r_q && (score_l_q != 4'd15))
                score_l_q <= score_l_q + 4'd1;
        end
    end

    assign miss_l  = miss_l_q;
    assign miss_r  = miss_r_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
`else
    assign miss_l  = 1'b0;
    assign miss_r  = 1'b0;
    assign score_l = 4'd0;
    assign score_r = 4'd0;
`endif

endmodule

// File: tb/tb_ball_collision_det.sv
// Randomised bench for ball_collision_det: an event-level model predicts output edges,
// a negedge monitor matches every observed edge/pulse against the expected-event queue.
module tb_ball_collision_det;
    localparam int R = 10, LX = 30, RX = 983, W = 10, H = 100, HOLD = 60;
    localparam int K_COL = 0, K_ML = 1, K_MR = 2, K_SL = 3, K_SR = 4;

    logic        pclk = 1'b0;
    logic        reset;
    logic [11:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic        collision_det, hit_side, miss_l, miss_r;
    logic [3:0]  score_l, score_r;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct { int kind; int cyc; int val; int side; } ev_t;
    ev_t evq[$];

    ball_collision_det #(.HOLD_MAX(HOLD)) dut (
        .pclk(pclk), .reset(reset),
        .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .collision_det(collision_det), .hit_side(hit_side),
        .miss_l(miss_l), .miss_r(miss_r), .score_l(score_l), .score_r(score_r)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    task automatic chk(input string name, input bit ok, input string act, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %s, expected %s", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int k, input int c, input int v, input int s);
        ev_t e;
        e.kind = k; e.cyc = c; e.val = v; e.side = s;
        evq.push_back(e);
    endtask

    // Pops the oldest expected event of this kind and compares it with what the DUT showed
    task automatic take(input int kind, input string name, input int val, input int side);
        int idx;
        ev_t e;
        idx = -1;
        for (int i = 0; i < evq.size(); i++)
            if (evq[i].kind == kind) begin idx = i; break; end
        if (idx < 0) begin
            chk(name, 1'b0, $sformatf("event val=%0d side=%0d", val, side), "no event");
        end else begin
            e = evq[idx];
            evq.delete(idx);
            chk(name, (e.cyc == cyc) && (e.val == val) && (e.side == side),
                $sformatf("cyc=%0d val=%0d side=%0d", cyc, val, side),
                $sformatf("cyc=%0d val=%0d side=%0d", e.cyc, e.val, e.side));
        end
    endtask

    task automatic flush_check(input int upto);
        foreach (evq[i])
            if (evq[i].cyc <= upto)
                chk("missing_event", 1'b0, "nothing",
                    $sformatf("kind=%0d cyc=%0d val=%0d", evq[i].kind, evq[i].cyc, evq[i].val));
        evq.delete();
    endtask

    // ---------------- reference model ----------------
    function automatic bit vert(input int y, input int p);
        return (y + R >= p) && (y < p + H + R);
    endfunction
    function automatic bit in_zl(input int x, input int y, input int p);
        return vert(y, p) && (x <= LX + W + R) && (x > LX + R);
    endfunction
    function automatic bit in_zr(input int x, input int y, input int p);
        return vert(y, p) && (x + R >= RX) && (x + R < RX + W);
    endfunction

    bit mp_zl, mp_zr, mp_wl, mp_wr;
    int mp_x;
    bit m_busy, m_wait;
    int m_side, m_hitx, m_start, m_sl, m_sr;
`ifdef COLLISION_SCORE_EN
    bit mpp_wl, mpp_wr;
`endif

    task automatic model_reset();
        flush_check(cyc);
        mp_zl = 0; mp_zr = 0; mp_wl = 0; mp_wr = 0; mp_x = 0;
        m_busy = 0; m_wait = 0; m_side = 0; m_hitx = 0; m_start = 0;
        m_sl = 0; m_sr = 0;
`ifdef COLLISION_SCORE_EN
        mpp_wl = 0; mpp_wr = 0;
`endif
    endtask

    // Edge e acts on the position seen at edge e-1 (one register stage of flags)
    task automatic model_step(input int e);
        int x, y, l, r;
        x = int'(ball_x); y = int'(ball_y); l = int'(pad_l_y); r = int'(pad_r_y);
        if (m_busy) begin
            if ((mp_x != m_hitx) || (e - m_start >= HOLD)) begin
                m_busy = 0; m_wait = 1;
                push(K_COL, e, 0, m_side);
            end
        end else if (m_wait) begin
            if (!mp_zl && !mp_zr) m_wait = 0;
        end else if (mp_zl || mp_zr) begin
            m_busy = 1; m_side = mp_zl ? 0 : 1; m_hitx = mp_x; m_start = e;
            push(K_COL, e, 1, m_side);
        end
`ifdef COLLISION_SCORE_EN
        if (mp_wl && !mpp_wl) begin
            push(K_ML, e, 1, 0);
            if (m_sr < 15) begin m_sr++; push(K_SR, e + 1, m_sr, 0); end
        end
        if (mp_wr && !mpp_wr) begin
            push(K_MR, e, 1, 0);
            if (m_sl < 15) begin m_sl++; push(K_SL, e + 1, m_sl, 0); end
        end
        mpp_wl = mp_wl; mpp_wr = mp_wr;
`endif
        mp_zl = in_zl(x, y, l);
        mp_zr = in_zr(x, y, r);
        mp_wl = (x <= R);
        mp_wr = (x + R >= 1023);
        mp_x  = x;
    endtask

    // ---------------- monitor ----------------
    logic       p_col;
    logic [3:0] p_sl, p_sr;
    always @(negedge pclk) begin
        if (reset) begin
            p_col = 1'b0; p_sl = 4'd0; p_sr = 4'd0;
        end else begin
            if (collision_det !== p_col) take(K_COL, "collision_det", int'(collision_det), int'(hit_side));
            if (miss_l) take(K_ML, "miss_l", 1, 0);
            if (miss_r) take(K_MR, "miss_r", 1, 0);
            if (score_l !== p_sl) take(K_SL, "score_l", int'(score_l), 0);
            if (score_r !== p_sr) take(K_SR, "score_r", int'(score_r), 0);
            p_col = collision_det; p_sl = score_l; p_sr = score_r;
        end
    end

    // ---------------- stimulus ----------------
    logic [11:0] nx, ny, nl, nr;

    task automatic set_pos(input int x, input int y, input int l, input int r);
        nx = 12'(x); ny = 12'(y); nl = 12'(l); nr = 12'(r);
    endtask

    task automatic apply();
        ball_x = nx; ball_y = ny; pad_l_y = nl; pad_r_y = nr;
        model_step(cyc + 1);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge pclk); #1;
            apply();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_collision_det"}, collision_det == 1'b0, $sformatf("%0b", collision_det), "0");
        chk({tag, "_hit_side"},      hit_side == 1'b0,      $sformatf("%0b", hit_side), "0");
        chk({tag, "_miss_l"},        miss_l == 1'b0,        $sformatf("%0b", miss_l), "0");
        chk({tag, "_miss_r"},        miss_r == 1'b0,        $sformatf("%0b", miss_r), "0");
        chk({tag, "_score_l"},       score_l == 4'd0,       $sformatf("%0d", score_l), "0");
        chk({tag, "_score_r"},       score_r == 4'd0,       $sformatf("%0d", score_r), "0");
    endtask

    initial begin
        int x, y, l, r, k, len;
        reset = 1'b1;
        ball_x = '0; ball_y = '0; pad_l_y = '0; pad_r_y = '0;
        set_pos(500, 350, 300, 600);
        model_reset();
        @(negedge pclk); #1;
        check_all_zero("reset");
        @(negedge pclk); #1;
        reset = 1'b0;
        apply();
        run(3);

        // left hit, then mover steps by one pixel
        set_pos(60, 350, 300, 600);  run(3);
        set_pos(50, 350, 300, 600);  run(5);
        set_pos(51, 350, 300, 600);  run(6);
        set_pos(500, 350, 300, 600); run(3);

        // right hit on the lower edge overlap, then just outside it
        set_pos(973, 205, 600, 100); run(6);
        set_pos(500, 205, 600, 100); run(3);
        set_pos(973, 211, 600, 100); run(6);
        set_pos(500, 211, 600, 100); run(3);

        // timeout with a static ball, then leave and return
        set_pos(45, 350, 300, 600);  run(HOLD + 10);
        set_pos(100, 350, 300, 600); run(3);
        set_pos(45, 350, 300, 600);  run(6);
        set_pos(500, 350, 300, 600); run(3);

        // wall misses up to and past saturation
        set_pos(10, 350, 300, 600); run(5);
        for (int i = 0; i < 17; i++) begin
            set_pos(100, 350, 300, 600); run(2);
            set_pos(10, 350, 300, 600);  run(2);
        end
        run(10);
        for (int i = 0; i < 3; i++) begin
            set_pos(900, 350, 300, 600);  run(2);
            set_pos(1015, 350, 300, 600); run(3);
        end
        set_pos(500, 350, 300, 600); run(3);

        // randomised positions biased towards paddle zones, walls and edges
        for (int s = 0; s < 300; s++) begin
            k = $urandom_range(0, 5);
            case (k)
                0:       x = $urandom_range(36, 55);
                1:       x = $urandom_range(968, 987);
                2:       x = $urandom_range(0, 14);
                3:       x = $urandom_range(1008, 1023);
                default: x = $urandom_range(0, 1023);
            endcase
            l = $urandom_range(0, 700);
            r = $urandom_range(0, 700);
            y = (x < 512 ? l : r) + int'($urandom_range(0, 130)) - 15;
            if (y < 0) y = 0;
            if ($urandom_range(0, 15) == 0) begin
                y = $urandom_range(3900, 4095);
                l = $urandom_range(3900, 4095);
                r = $urandom_range(3900, 4095);
            end
            len = ($urandom_range(0, 30) == 0) ? HOLD + 5 : $urandom_range(1, 6);
            set_pos(x, y, l, r);
            run(len);
        end

        // asynchronous reset while a hit is held
        set_pos(500, 350, 300, 600); run(HOLD + 5);
        set_pos(45, 350, 300, 600);  run(4);
        chk("pre_reset_collision", collision_det == 1'b1 && m_busy, $sformatf("%0b", collision_det), "1");
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge pclk);
        @(negedge pclk); #1;
        reset = 1'b0;
        apply();
        run(6);

        @(negedge pclk);
        @(negedge pclk); #1;
        flush_check(cyc);
        chk("final_score_l", int'(score_l) == m_sl, $sformatf("%0d", score_l), $sformatf("%0d", m_sl));
        chk("final_score_r", int'(score_r) == m_sr, $sformatf("%0d", score_r), $sformatf("%0d", m_sr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
